// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - breathing-profile sequencer for a PWM generator (optional macro PWM_RAMP_LOOP_EN)
module pwm_ramp_ctrl #(
    parameter int CW = 32,
    parameter int HW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_duty_max,
    input  logic [CW-1:0] cfg_step,
    input  logic [HW-1:0] cfg_hold,
    input  logic          start,
    input  logic          abort,
    output logic          pwm_gen_en,
    output logic [CW-1:0] counter_arr,
    output logic [CW-1:0] counter_compare,
    output logic          period_tick,
    output logic          busy,
`ifdef PWM_RAMP_LOOP_EN
    output logic [15:0]   loop_cnt,
`endif
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_UP,
        S_HOLD,
        S_RAMP_DOWN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;

    // shadow configuration
    logic [CW-1:0] period_q, duty_q, step_q;
    logic [HW-1:0] hold_cfg_q;
    logic          cfg_loaded;

    // sequencing datapath
    logic [CW-1:0] cmp_q, cmp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;

    logic          cfg_accept, start_go, running, tick;
    logic [CW-1:0] period_clamp, duty_clamp, step_clamp;
    logic [CW:0]   up_sum;
    logic [CW-1:0] up_val, dn_val;

`ifdef PWM_RAMP_LOOP_EN
    logic [15:0]   loop_q, loop_d;
    assign loop_cnt = loop_q;
`endif

    // abort outranks config, so the handshake is withheld while it is asserted
    assign cfg_ready  = (state_q == S_IDLE) && !abort;
    assign cfg_accept = cfg_valid && cfg_ready;

    // clamp at capture so the running datapath never sees degenerate values
    assign period_clamp = (cfg_period < CW'(2)) ? CW'(2) : cfg_period;
    assign duty_clamp   = (cfg_duty_max > period_clamp) ? period_clamp : cfg_duty_max;
    assign step_clamp   = (cfg_step == '0) ? CW'(1) : cfg_step;

    // a config accepted in the same cycle as start counts as loaded
    assign start_go = (state_q == S_IDLE) && start && !abort && (cfg_loaded || cfg_accept);

    assign running = (state_q == S_RAMP_UP) || (state_q == S_HOLD) || (state_q == S_RAMP_DOWN);
    assign tick    = running && (cnt_q == period_q);

    // one extra bit on the ramp-up sum so saturation cannot be defeated by wrap
    assign up_sum = {1'b0, cmp_q} + {1'b0, step_q};
    assign up_val = (up_sum > {1'b0, duty_q}) ? duty_q : up_sum[CW-1:0];
    assign dn_val = (cmp_q > step_q) ? (cmp_q - step_q) : '0;

    assign counter_arr     = period_q;
    assign counter_compare = cmp_q;

    // capture clamped configuration into the shadow registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            period_q   <= '0;
            duty_q     <= '0;
            step_q     <= '0;
            hold_cfg_q <= '0;
            cfg_loaded <= 1'b0;
        end else if (cfg_accept) begin
            period_q   <= period_clamp;
            duty_q     <= duty_clamp;
            step_q     <= step_clamp;
            hold_cfg_q <= cfg_hold;
            cfg_loaded <= 1'b1;
        end
    end

    // state and sequencing datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cmp_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
`ifdef PWM_RAMP_LOOP_EN
            loop_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
`ifdef PWM_RAMP_LOOP_EN
            loop_q  <= loop_d;
`endif
        end
    end

    // next-state, compare stepping at period boundaries, and status outputs
    always_comb begin
        state_d     = state_q;
        cmp_d       = cmp_q;
        hold_d      = hold_q;
        cnt_d       = running ? (tick ? CW'(1) : cnt_q + CW'(1)) : cnt_q;
`ifdef PWM_RAMP_LOOP_EN
        loop_d      = loop_q;
`endif
        busy        = running;
        pwm_gen_en  = running;
        period_tick = tick;
        done        = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start_go) begin
                    state_d = S_RAMP_UP;
                    cmp_d   = '0;
                    cnt_d   = CW'(1);
`ifdef PWM_RAMP_LOOP_EN
                    loop_d  = '0;
`endif
                end
            end
            S_RAMP_UP: begin
                if (tick) begin
                    cmp_d = up_val;
                    if (up_val == duty_q) begin
                        if (hold_cfg_q == '0) begin
                            state_d = S_RAMP_DOWN;
                        end else begin
                            state_d = S_HOLD;
                            hold_d  = hold_cfg_q;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    hold_d = hold_q - HW'(1);
                    if (hold_q == HW'(1)) begin
                        state_d = S_RAMP_DOWN;
                    end
                end
            end
            S_RAMP_DOWN: begin
                if (tick) begin
                    cmp_d = dn_val;
                    if (dn_val == '0) begin
`ifdef PWM_RAMP_LOOP_EN
                        state_d = S_RAMP_UP;
                        loop_d  = loop_q + 16'd1;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort wins over everything else and skips the done pulse
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cmp_d   = '0;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - self-checking bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_period = '0;
    logic [31:0] cfg_duty_max = '0;
    logic [31:0] cfg_step = '0;
    logic [15:0] cfg_hold = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pwm_gen_en;
    logic [31:0] counter_arr;
    logic [31:0] counter_compare;
    logic        period_tick;
    logic        busy;
    logic        done;
`ifdef PWM_RAMP_LOOP_EN
    logic [15:0] loop_cnt;
`endif

    pwm_ramp_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_period     (cfg_period),
        .cfg_duty_max   (cfg_duty_max),
        .cfg_step       (cfg_step),
        .cfg_hold       (cfg_hold),
        .start          (start),
        .abort          (abort),
        .pwm_gen_en     (pwm_gen_en),
        .counter_arr    (counter_arr),
        .counter_compare(counter_compare),
        .period_tick    (period_tick),
        .busy           (busy),
`ifdef PWM_RAMP_LOOP_EN
        .loop_cnt       (loop_cnt),
`endif
        .done           (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // advance to just after the next falling edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] period;
        logic [31:0] duty;
        logic [31:0] stp;
        logic [15:0] hold;
        bit          same;
        logic [31:0] exp_arr;
        int          first;
        int          n;
    } vec_t;

    vec_t vecs[5];

    // expected compare value after each tick, per vector
    int seq_tab [28] = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0,
                         4, 8, 10, 6, 2, 0,
                         1, 2, 1, 0,
                         0, 0, 0,
                         3, 4, 4, 1, 0};

    // scoreboard and tick monitor
    int          exp_q[$];
    int          cyc = 0;
    int          last_tick_cyc = 0;
    int          tick_cnt = 0;
    bit          tick_seen = 1'b0;
    bit          busy_prev = 1'b0;
    bit          sb_en = 1'b0;
    logic [31:0] exp_arr_mon = '0;

    always @(negedge clk) begin
        int e;
        cyc++;
        if (tick_seen && sb_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tick", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("compare_after_tick", counter_compare, e);
            end
        end
        if (busy && !busy_prev) begin
            last_tick_cyc = cyc - 1;
            tick_cnt      = 0;
        end
        if (period_tick) begin
            tick_cnt++;
            if (sb_en) check("tick_interval", cyc - last_tick_cyc, exp_arr_mon);
            last_tick_cyc = cyc;
        end
        tick_seen = period_tick;
        busy_prev = busy;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_en"}, pwm_gen_en, 0);
        check({tag, "_arr"}, counter_arr, 0);
        check({tag, "_compare"}, counter_compare, 0);
        check({tag, "_tick"}, period_tick, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cfg_ready"}, cfg_ready, 1);
    endtask

    task automatic load_cfg(input logic [31:0] p, input logic [31:0] d, input logic [31:0] s,
                            input logic [15:0] h);
        cfg_period   = p;
        cfg_duty_max = d;
        cfg_step     = s;
        cfg_hold     = h;
        cfg_valid    = 1'b1;
        step();
        cfg_valid    = 1'b0;
    endtask

    task automatic wait_ticks(input int target, input string name);
        for (int k = 0; k < 3000 && tick_cnt < target; k++) step();
        if (tick_cnt < target) check({name, "_timeout"}, tick_cnt, target);
    endtask

    task automatic run_vec(input vec_t v);
        exp_arr_mon = v.exp_arr;
        sb_en       = 1'b1;
        if (!v.same) begin
            load_cfg(v.period, v.duty, v.stp, v.hold);
            check("arr_on_accept", counter_arr, v.exp_arr);
        end
        for (int k = 0; k < v.n; k++) exp_q.push_back(seq_tab[v.first + k]);
        cfg_period   = v.period;
        cfg_duty_max = v.duty;
        cfg_step     = v.stp;
        cfg_hold     = v.hold;
        cfg_valid    = v.same;
        start        = 1'b1;
        step();
        start        = 1'b0;
        cfg_valid    = 1'b0;
        check("busy_on_start", busy, 1);
        check("en_on_start", pwm_gen_en, 1);
        check("compare_on_start", counter_compare, 0);
        check("arr_running", counter_arr, v.exp_arr);
        check("cfg_ready_running", cfg_ready, 0);
        for (int k = 0; k < 3000 && !done; k++) step();
        if (!done) begin
            check("done_timeout", 0, 1);
        end else begin
            check("tick_count", tick_cnt, v.n);
            check("done_latency", cyc - last_tick_cyc, 1);
            check("queue_drained", exp_q.size(), 0);
            check("en_at_done", pwm_gen_en, 0);
            check("busy_at_done", busy, 0);
            step();
            check("done_one_cycle", done, 0);
            check("cfg_ready_after", cfg_ready, 1);
        end
        sb_en = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{32'd10, 32'd4,  32'd1, 16'd2, 1'b0, 32'd10, 0,  10};
        vecs[1] = '{32'd20, 32'd10, 32'd4, 16'd0, 1'b1, 32'd20, 10, 6};
        vecs[2] = '{32'd1,  32'd9,  32'd0, 16'd0, 1'b1, 32'd2,  16, 4};
        vecs[3] = '{32'd3,  32'd0,  32'd5, 16'd1, 1'b0, 32'd3,  20, 3};
        vecs[4] = '{32'd4,  32'd7,  32'd3, 16'd1, 1'b0, 32'd4,  23, 5};

        // reset state
        reset_n = 1'b0;
        step();
        step();
        check_reset_vals("reset");
        reset_n = 1'b1;
        step();

        // start with no config loaded is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_no_cfg_busy", busy, 0);
        check("start_no_cfg_en", pwm_gen_en, 0);

`ifndef PWM_RAMP_LOOP_EN
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
`endif

        // config while busy is refused, then abort during HOLD
        load_cfg(32'd10, 32'd4, 32'd1, 16'd3);
        start = 1'b1;
        step();
        start        = 1'b0;
        cfg_period   = 32'd50;
        cfg_duty_max = 32'd7;
        cfg_valid    = 1'b1;
        step();
        check("cfg_ready_busy", cfg_ready, 0);
        step();
        cfg_valid = 1'b0;
        check("arr_unchanged_busy", counter_arr, 10);
        wait_ticks(5, "hold_wait");
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_en", pwm_gen_en, 0);
        check("abort_compare", counter_compare, 0);
        check("abort_done", done, 0);
        check("abort_cfg_ready", cfg_ready, 1);
        step();
        check("abort_no_done_later", done, 0);

        // abort together with start in IDLE stays idle
        abort = 1'b1;
        start = 1'b1;
        step();
        check("abort_start_idle", busy, 0);
        abort = 1'b0;
        start = 1'b0;
        step();
        check("abort_start_idle_after", busy, 0);

        // reset mid-sequence clears everything including loaded config
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 15; k++) step();
        check("busy_before_reset", busy, 1);
        reset_n = 1'b0;
        step();
        check_reset_vals("midreset");
        reset_n = 1'b1;
        start   = 1'b1;
        step();
        start = 1'b0;
        check("start_after_reset", busy, 0);

`ifdef PWM_RAMP_LOOP_EN
        // looping profile, reset in RAMP_DOWN of the fourth pass
        load_cfg(32'd4, 32'd2, 32'd1, 16'd0);
        exp_arr_mon = 32'd4;
        sb_en       = 1'b1;
        for (int l = 0; l < 3; l++) begin
            exp_q.push_back(1);
            exp_q.push_back(2);
            exp_q.push_back(1);
            exp_q.push_back(0);
        end
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("loop_cnt_start", loop_cnt, 0);
        wait_ticks(15, "loop_wait");
        step();
        check("loop_cnt_3", loop_cnt, 3);
        check("loop_busy", busy, 1);
        check("loop_compare_down", counter_compare, 1);
        check("loop_queue_drained", exp_q.size(), 0);
        sb_en = 1'b0;
        exp_q.delete();
        reset_n = 1'b0;
        step();
        check_reset_vals("loopreset");
        check("loop_cnt_reset", loop_cnt, 0);
        reset_n = 1'b1;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // absolute guard against a hung run
    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
